velopix_descrambler30: RTL and testbench

//  Receive-side counterpart of the 30-bit VeloPix parallel scrambler: recovers 30-bit packets from scrambled words.

---
 rtl/velopix_scrambler_pkg.sv | 41 ++++
 rtl/velopix_descramble_comb.sv | 12 +
 rtl/velopix_descrambler30.sv | 129 ++++++++++++
 tb/tb_velopix_descrambler30.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/velopix_scrambler_pkg.sv
// Shared definitions for the 30-bit VeloPix scrambler/descrambler pair.
// Polynomial x^30+x^29+x^15+x^14+1; bit 0 of a word is the earliest serial bit.
package velopix_scrambler_pkg;

    localparam int WORD_W = 30;

    // Serial tap distances of the polynomial.
    localparam int TAP_A = 14;
    localparam int TAP_B = 15;
    localparam int TAP_C = 29;
    localparam int TAP_D = 30;

    // History value loaded after reset/resync; the transmitter resets to the same value.
    localparam logic [WORD_W-1:0] SCR_SEED = 30'h2AAAAAAA;

    typedef enum logic [1:0] {
        SEED_ST = 2'd0,
        FILL    = 2'd1,
        LOCKED  = 2'd2
    } desc_state_e;

    // Feed-forward descramble of one word.
    // The current word sits above the previous word, so serial position m maps to ext[m+WORD_W]
    // and any tap reaching back past bit 0 lands in the history half.
    function automatic logic [WORD_W-1:0] descramble_word(input logic [WORD_W-1:0] cur,
                                                          input logic [WORD_W-1:0] hist);
        logic [2*WORD_W-1:0] ext;
        logic [WORD_W-1:0]   res;
        ext = {cur, hist};
        res = {WORD_W{1'b0}};
        for (int i = 0; i < WORD_W; i++) begin
            res[i] = ext[i+WORD_W]
                   ^ ext[i+WORD_W-TAP_A]
                   ^ ext[i+WORD_W-TAP_B]
                   ^ ext[i+WORD_W-TAP_C]
                   ^ ext[i+WORD_W-TAP_D];
        end
        return res;
    endfunction

endpackage

// File: rtl/velopix_descramble_comb.sv
// Pure combinational word descrambler: received word plus previous received word -> recovered word.
module velopix_descramble_comb
    import velopix_scrambler_pkg::*;
(
    input  logic [WORD_W-1:0] data_i,
    input  logic [WORD_W-1:0] hist_i,
    output logic [WORD_W-1:0] data_o
);

    assign data_o = descramble_word(data_i, hist_i);

endmodule

// File: rtl/velopix_descrambler30.sv
// Receive-side self-synchronising descrambler for 30-bit VeloPix words.
// Holds the history register, the lock FSM, the word counter and the output registers.
module velopix_descrambler30
    import velopix_scrambler_pkg::*;
#(
    parameter logic [WORD_W-1:0] SEED       = SCR_SEED,
    parameter int                LOCK_WORDS = 1,
    parameter int                CNT_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              descramble_i,
    input  logic              resync_i,
    output logic              valid_o,
    output logic [WORD_W-1:0] data_o,
    output logic              lock_o,
    output logic [CNT_W-1:0]  word_count_o
);

    localparam int                FILL_W      = $clog2(LOCK_WORDS + 1);
    localparam logic [FILL_W-1:0] FILL_TARGET = FILL_W'(LOCK_WORDS);

    logic [WORD_W-1:0] hist_q, hist_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q;
    logic              lock_q;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_inc_s;
    desc_state_e       state_q;
    logic [WORD_W-1:0] desc_s;
    logic              take_s;

    velopix_descramble_comb u_comb (
        .data_i (data_i),
        .hist_i (hist_q),
        .data_o (desc_s)
    );

    // A word that actually advances the descrambler (resync suppresses it).
    assign take_s     = valid_i & descramble_i & ~resync_i;
    assign fill_inc_s = fill_q + {{(FILL_W-1){1'b0}}, 1'b1};

    // Next-state for history, output word and counter; resync overrides history/counter updates.
    always_comb begin
        hist_d = hist_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (resync_i) begin
            hist_d = SEED;
            cnt_d  = {CNT_W{1'b0}};
            if (valid_i) begin
                data_d = data_i;
            end else begin
                data_d = data_q;
            end
        end else if (valid_i) begin
            if (descramble_i) begin
                data_d = desc_s;
                hist_d = data_i;
                cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                data_d = data_i;
            end
        end else begin
            data_d = data_q;
        end
    end

    // Datapath registers: history, output word, valid and word counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_q  <= SEED;
            data_q  <= {WORD_W{1'b0}};
            valid_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            hist_q  <= hist_d;
            data_q  <= data_d;
            valid_q <= valid_i;
            cnt_q   <= cnt_d;
        end
    end

    // Lock FSM: lock rises together with the output of the LOCK_WORDS-th descrambled word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= SEED_ST;
            fill_q  <= {FILL_W{1'b0}};
            lock_q  <= 1'b0;
        end else if (resync_i) begin
            state_q <= SEED_ST;
            fill_q  <= {FILL_W{1'b0}};
            lock_q  <= 1'b0;
        end else if (take_s) begin
            case (state_q)
                SEED_ST, FILL: begin
                    fill_q <= fill_inc_s;
                    if (fill_inc_s == FILL_TARGET) begin
                        state_q <= LOCKED;
                        lock_q  <= 1'b1;
                    end else begin
                        state_q <= FILL;
                        lock_q  <= 1'b0;
                    end
                end
                LOCKED: begin
                    state_q <= LOCKED;
                    lock_q  <= 1'b1;
                end
                default: begin
                    state_q <= SEED_ST;
                    fill_q  <= {FILL_W{1'b0}};
                    lock_q  <= 1'b0;
                end
            endcase
        end else begin
            state_q <= state_q;
        end
    end

    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign lock_o       = lock_q;
    assign word_count_o = cnt_q;

endmodule

// File: tb/tb_velopix_descrambler30.sv
// Directed bench for velopix_descrambler30 with a bit-serial scrambler as the transmit model.
module tb_velopix_descrambler30;

    localparam logic [29:0] SEED = 30'h2AAAAAAA;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        valid_i = 1'b0;
    logic [29:0] data_i = 30'd0;
    logic        descramble_i = 1'b1;
    logic        resync_i = 1'b0;

    logic        valid_o, valid3_o;
    logic [29:0] data_o, data3_o;
    logic        lock_o, lock3_o;
    logic [31:0] cnt_o, cnt3_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [29:0] tx_hist;

    always #5 clock = ~clock;

    velopix_descrambler30 #(.SEED(SEED), .LOCK_WORDS(1), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .valid_i(valid_i), .data_i(data_i),
        .descramble_i(descramble_i), .resync_i(resync_i), .valid_o(valid_o),
        .data_o(data_o), .lock_o(lock_o), .word_count_o(cnt_o));

    velopix_descrambler30 #(.SEED(SEED), .LOCK_WORDS(3), .CNT_W(32)) dut3 (
        .clock(clock), .reset(reset), .valid_i(valid_i), .data_i(data_i),
        .descramble_i(descramble_i), .resync_i(resync_i), .valid_o(valid3_o),
        .data_o(data3_o), .lock_o(lock3_o), .word_count_o(cnt3_o));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Serial scrambler: s[n] = d[n]^s[n-14]^s[n-15]^s[n-29]^s[n-30], computed bit by bit.
    function automatic logic [29:0] scr(input logic [29:0] d, input logic [29:0] h);
        logic [59:0] e;
        e = {30'd0, h};
        for (int i = 0; i < 30; i++) begin
            e[30+i] = d[i] ^ e[30+i-14] ^ e[30+i-15] ^ e[30+i-29] ^ e[30+i-30];
        end
        return e[59:30];
    endfunction

    // Drive one cycle of inputs at negedge; return #1 after the capturing edge.
    task automatic send(input logic v, input logic [29:0] d, input logic desc, input logic rs);
        @(negedge clock);
        valid_i = v;
        data_i = d;
        descramble_i = desc;
        resync_i = rs;
        @(posedge clock);
        #1;
        valid_i = 1'b0;
        resync_i = 1'b0;
    endtask

    task automatic tx_send(input logic [29:0] d);
        logic [29:0] s;
        s = scr(d, tx_hist);
        tx_hist = s;
        send(1'b1, s, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        tx_hist = SEED;
    endtask

    initial begin
        logic [29:0] d;
        logic [29:0] s;
        logic [29:0] held;

        // Reset state
        #12;
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_data", {34'd0, data_o}, 64'd0);
        chk("rst_lock", {63'd0, lock_o}, 64'd0);
        chk("rst_count", {32'd0, cnt_o}, 64'd0);
        chk("rst_lock3", {63'd0, lock3_o}, 64'd0);
        do_reset();

        // Loopback: 1000 random words
        for (int i = 0; i < 1000; i++) begin
            d = 30'($urandom);
            tx_send(d);
            chk("loop_data", {34'd0, data_o}, {34'd0, d});
            chk("loop_lock", {63'd0, lock_o}, 64'd1);
            if (i < 3) begin
                chk("loop_valid", {63'd0, valid_o}, 64'd1);
                chk("loop_lock3", {63'd0, lock3_o}, (i == 2) ? 64'd1 : 64'd0);
            end
        end
        chk("loop_count", {32'd0, cnt_o}, 64'd1000);

        // Bypass: history and counter hold across bypass words
        do_reset();
        for (int i = 0; i < 25; i++) begin
            if (i >= 10 && i < 15) begin
                send(1'b1, 30'h3FFFFFFF, 1'b0, 1'b0);
                chk("byp_raw", {34'd0, data_o}, {34'd0, 30'h3FFFFFFF});
            end else begin
                d = 30'($urandom);
                tx_send(d);
                chk("byp_data", {34'd0, data_o}, {34'd0, d});
            end
        end
        chk("byp_count", {32'd0, cnt_o}, 64'd20);

        // Self-sync: tx runs 7 words ahead of the DUT reset
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tx_hist = scr(30'($urandom), tx_hist);
        end
        for (int i = 0; i < 10; i++) begin
            d = 30'($urandom);
            tx_send(d);
            if (i > 0) chk("sync_data", {34'd0, data_o}, {34'd0, d});
        end

        // Single bit error on word 3 of an all-zero stream
        do_reset();
        for (int i = 0; i < 7; i++) begin
            s = scr(30'd0, tx_hist);
            tx_hist = s;
            if (i == 3) s[20] = ~s[20];
            send(1'b1, s, 1'b1, 1'b0);
            if (i == 3)      chk("berr_k", {34'd0, data_o}, {34'd0, 30'h00100000});
            else if (i == 4) chk("berr_k1", {34'd0, data_o}, {34'd0, 30'h00180030});
            else             chk("berr_clean", {34'd0, data_o}, 64'd0);
        end

        // Gaps: valid 1-0-0-1
        d = 30'h1234567;
        tx_send(d);
        held = d;
        for (int i = 0; i < 2; i++) begin
            send(1'b0, 30'h3C3C3C3, 1'b1, 1'b0);
            chk("gap_valid", {63'd0, valid_o}, 64'd0);
            chk("gap_hold", {34'd0, data_o}, {34'd0, held});
        end
        d = 30'h2ABCDEF;
        tx_send(d);
        chk("gap_data", {34'd0, data_o}, {34'd0, d});

        // Resync with a word present: passed through raw, lock and counter dropped
        send(1'b1, 30'h15555555, 1'b1, 1'b1);
        tx_hist = SEED;
        chk("rs_raw", {34'd0, data_o}, {34'd0, 30'h15555555});
        chk("rs_valid", {63'd0, valid_o}, 64'd1);
        chk("rs_lock", {63'd0, lock_o}, 64'd0);
        chk("rs_lock3", {63'd0, lock3_o}, 64'd0);
        chk("rs_count", {32'd0, cnt_o}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            d = 30'($urandom);
            tx_send(d);
            chk("rs_data", {34'd0, data_o}, {34'd0, d});
            chk("rs_lock3_seq", {63'd0, lock3_o}, (i >= 2) ? 64'd1 : 64'd0);
            chk("rs_cnt3", {32'd0, cnt3_o}, 64'(i + 1));
        end

        // Asynchronous reset during a burst
        for (int i = 0; i < 3; i++) tx_send(30'($urandom));
        reset = 1'b0;
        #1;
        chk("arst_valid", {63'd0, valid_o}, 64'd0);
        chk("arst_data", {34'd0, data_o}, 64'd0);
        chk("arst_lock", {63'd0, lock_o}, 64'd0);
        chk("arst_count", {32'd0, cnt_o}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        tx_hist = SEED;
        d = 30'h0F0F0F0;
        tx_send(d);
        chk("arst_first", {34'd0, data_o}, {34'd0, d});
        chk("arst_cnt1", {32'd0, cnt_o}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
